bias_stream_reader: RTL and testbench
=====================================

Name: bias_stream_reader

Overview:
- Read-side consumer of the per-layer packed bias LUTs; one start per layer fetches the packed bias word and emits it as a stream of signed biases, one channel per beat.
- Downstream accumulator or PE bias-add stage consumes the stream over a valid/ready handshake.
- Sits between the layer sequencer (start, layer number) and the bias-add stage. The LUT stays external and combinational.

Parameters:
- BIAS_W, 16, width of one packed bias (two's complement).
- MAX_BIAS, 36, largest per-layer bias count; packed input width = BIAS_W*MAX_BIAS = 576.
- ACC_W, 32, output width; bias is sign-extended to this.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a layer's bias stream; sampled only when busy=0.
- layer  in  4  layer number, valid 1..9.
- lut_addr  out  4  address to the bias LUT (registered).
- lut_data  in  576  packed LUT word, right-aligned (LSBs); combinational from lut_addr.
- bias_valid  out  1  bias_data valid.
- bias_ready  in  1  consumer accepts the beat.
- bias_data  out  ACC_W  sign-extended bias.
- bias_chan  out  6  channel index of the current beat, 0-based.
- bias_last  out  1  high on the final channel's beat.
- busy  out  1  high from the accepted start to the final handshake.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  one-cycle pulse on start with an illegal layer.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - lut_addr=0, bias_valid=0, bias_data=0, bias_chan=0, bias_last=0.
  - busy=0, done=0, err=0, internal count and shift register cleared.
- Bias count N(layer): 1-3 -> 12; 4-6 -> 24; 7-8 -> 36; 9 -> 10; other values are illegal.
- Packing: used width 16*N sits at lut_data[16*N-1:0]. Channel 0 is the most significant slice [16*N-1 -: 16]; channel N-1 is [15:0].
- FSM states and transitions:
  - IDLE: start=1 with a legal layer -> lut_addr<=layer, busy<=1, go to FETCH.
  - IDLE, illegal layer: start=1 -> err pulses one cycle; no other state change.
  - FETCH: capture lut_data, left-aligned by (MAX_BIAS-N)*16, into the shift register. Load remaining<=N, bias_chan<=0, bias_valid<=1, go to STREAM.
  - STREAM: bias_data is the sign-extended top 16 bits of the shift register.
    - On bias_valid&&bias_ready, shift left 16 and increment bias_chan.
    - bias_last=1 when bias_chan==N-1.
    - On the last handshake: bias_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- Latency: start sampled at edge E0; bias_valid is visible after edge E1. With bias_ready held high, the stream takes N consecutive cycles.
- Handshake rules:
  - While bias_valid=1 and bias_ready=0, bias_data, bias_chan and bias_last hold stable.
  - bias_valid never drops before its handshake.
- start while busy=1 is ignored; no queueing and no err.
- done and a new start in the same cycle is legal. The start is accepted because state is already IDLE.
- Reset mid-stream aborts immediately. No done is issued; outputs take their reset values.
- layer is sampled only at start acceptance; later changes have no effect.

Decomposition:
- Shared package bias_pkg holds:
  - BIAS_W, MAX_BIAS and the layer-count constants (12/24/36/10).
  - A function bias_count(layer) returning N, or 0 for an illegal layer.
  - The FSM state enum (IDLE, FETCH, STREAM).
- No sub-module is needed: the count lookup is a package function and the shift register is inline.
- Top-level integration instantiates lut_biases_1..9 and ORs their outputs onto lut_data. Each LUT is zero-padded to 576 bits and drives zeros when not addressed.

Test Plan:
- Layer 1, ready held high -> 12 beats on consecutive cycles after E1.
  - Beats 0..4 = 0x0001, 0x007D, 0x0027, 0x0003, 0xFFFFFFF0 (-16).
  - Beat 11 = 0x00000044 with bias_last=1; done pulses on the next cycle.
- Layer 9 -> 10 beats, beat 0 = 0xFFFFFFF0, beat 9 = 0xFFFFFFF2 (-14), bias_chan 0..9.
- Layer 8, bias_ready toggled 1/0 randomly -> exactly 36 handshakes; data stable during stalls.
  - Beat 0 = 0x0000000F, beat 35 = 0x00000014.
- start with layer=0, then with layer=10 -> err pulses each time; busy stays 0; bias_valid never rises.
- start with layer=2 during a layer-4 stream -> ignored; the layer-4 stream completes its 24 beats, channel 0 = 0xFFFFFFFA.
- Layer 7 stream with rst_n asserted at beat 5 -> all outputs zero asynchronously; no done.
  - After release, a layer-3 start streams 12 beats starting with 0x0000001A.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared constants, state encoding and helpers for the bias stream reader.
// The packed LUT word holds up to MAX_BIAS two's-complement biases of BIAS_W
// bits each, right-aligned, with channel 0 in the most significant used slice.
package bias_pkg;

  localparam int BIAS_W   = 16;
  localparam int MAX_BIAS = 36;
  localparam int ACC_W    = 32;
  localparam int PACK_W   = BIAS_W * MAX_BIAS;
  localparam int LAYER_W  = 4;
  localparam int CHAN_W   = 6;
  localparam int SHAMT_W  = 10;

  // Per-layer bias counts
  localparam logic [CHAN_W-1:0] N_LAYER_1_3 = 6'd12;
  localparam logic [CHAN_W-1:0] N_LAYER_4_6 = 6'd24;
  localparam logic [CHAN_W-1:0] N_LAYER_7_8 = 6'd36;
  localparam logic [CHAN_W-1:0] N_LAYER_9   = 6'd10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_e;

  // Number of biases stored for a layer; 0 marks an illegal layer number.
  function automatic logic [CHAN_W-1:0] bias_count(input logic [LAYER_W-1:0] layer);
    logic [CHAN_W-1:0] n;
    case (layer)
      4'd1, 4'd2, 4'd3: n = N_LAYER_1_3;
      4'd4, 4'd5, 4'd6: n = N_LAYER_4_6;
      4'd7, 4'd8:       n = N_LAYER_7_8;
      4'd9:             n = N_LAYER_9;
      default:          n = '0;
    endcase
    return n;
  endfunction

  // Sign-extend one bias to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_bias(input logic [BIAS_W-1:0] b);
    return {{(ACC_W - BIAS_W){b[BIAS_W-1]}}, b};
  endfunction

endpackage

// File: rtl/bias_stream_reader.sv
// Bias stream reader: on start, addresses the external combinational bias LUT
// with the layer number, captures the packed word one cycle later and emits
// its biases one channel per beat over a valid/ready handshake.
module bias_stream_reader
  import bias_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LAYER_W-1:0]  layer,
  output logic [LAYER_W-1:0]  lut_addr,
  input  logic [PACK_W-1:0]   lut_data,
  output logic                bias_valid,
  input  logic                bias_ready,
  output logic [ACC_W-1:0]    bias_data,
  output logic [CHAN_W-1:0]   bias_chan,
  output logic                bias_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              r_state;
  logic [PACK_W-1:0]   r_shift;
  logic [CHAN_W-1:0]   r_n;
  logic [CHAN_W-1:0]   r_remaining;
  logic [LAYER_W-1:0]  r_lut_addr;
  logic                r_bias_valid;
  logic [ACC_W-1:0]    r_bias_data;
  logic [CHAN_W-1:0]   r_bias_chan;
  logic                r_bias_last;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [CHAN_W-1:0]   w_start_n;
  logic                w_fire;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [PACK_W-1:0]   w_aligned;
  logic [PACK_W-1:0]   w_next_shift;
  logic [ACC_W-1:0]    w_first_data;
  logic [ACC_W-1:0]    w_next_data;

  assign w_start_n = bias_count(layer);
  assign w_fire    = r_bias_valid & bias_ready;

  // Left-align the used N slices so channel 0 always sits at the top.
  assign w_shamt      = SHAMT_W'((MAX_BIAS - 32'(r_n)) * BIAS_W);
  assign w_aligned    = lut_data << w_shamt;
  assign w_next_shift = r_shift << BIAS_W;

  // The beat after a handshake is the second slice of the current register.
  assign w_first_data = sext_bias(w_aligned[PACK_W-1 -: BIAS_W]);
  assign w_next_data  = sext_bias(r_shift[PACK_W-1-BIAS_W -: BIAS_W]);

  // Control FSM: accepts starts, fetches the LUT word and walks the channels.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      // NOTE: the wide shift register is reset too, so an aborted stream
      // leaves no stale biases behind for observation or the next layer.
      r_shift      <= '0;
      r_n          <= '0;
      r_remaining  <= '0;
      r_lut_addr   <= '0;
      r_bias_valid <= 1'b0;
      r_bias_data  <= '0;
      r_bias_chan  <= '0;
      r_bias_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Pulses default low and are raised for exactly one cycle below.
      r_done <= 1'b0;
      r_err  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_start_n != '0) begin
              r_lut_addr <= layer;
              r_n        <= w_start_n;
              r_busy     <= 1'b1;
              r_state    <= FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        FETCH: begin
          r_shift      <= w_aligned;
          r_remaining  <= r_n;
          r_bias_chan  <= '0;
          r_bias_data  <= w_first_data;
          r_bias_last  <= (r_n == 6'd1);
          r_bias_valid <= 1'b1;
          r_state      <= STREAM;
        end

        STREAM: begin
          if (w_fire) begin
            if (r_bias_last) begin
              r_bias_valid <= 1'b0;
              r_bias_data  <= '0;
              r_bias_chan  <= '0;
              r_bias_last  <= 1'b0;
              r_remaining  <= '0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_shift     <= w_next_shift;
              r_bias_data <= w_next_data;
              r_bias_chan <= r_bias_chan + 6'd1;
              r_remaining <= r_remaining - 6'd1;
              r_bias_last <= (r_remaining == 6'd2);
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign lut_addr   = r_lut_addr;
  assign bias_valid = r_bias_valid;
  assign bias_data  = r_bias_data;
  assign bias_chan  = r_bias_chan;
  assign bias_last  = r_bias_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_bias_stream_reader.sv
// Directed testbench for bias_stream_reader with a behavioural bias LUT.
module tb_bias_stream_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   layer = 4'd0;
  logic [3:0]   lut_addr;
  logic [575:0] lut_data;
  logic         bias_valid;
  logic         bias_ready = 1'b0;
  logic [31:0]  bias_data;
  logic [5:0]   bias_chan;
  logic         bias_last;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;
  bit noise_start = 1'b0;

  always #5 clk = ~clk;

  bias_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .layer      (layer),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready),
    .bias_data  (bias_data),
    .bias_chan  (bias_chan),
    .bias_last  (bias_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  function automatic int tb_count(input logic [3:0] l);
    case (l)
      4'd1, 4'd2, 4'd3: return 12;
      4'd4, 4'd5, 4'd6: return 24;
      4'd7, 4'd8:       return 36;
      4'd9:             return 10;
      default:          return 0;
    endcase
  endfunction

  // Bias table: a few hand-chosen values, the rest a layer/channel pattern
  // with some negatives to exercise sign extension.
  function automatic logic [15:0] chan_val(input logic [3:0] l, input int c);
    logic [15:0] v;
    v = 16'(int'(l) * 256 + c);
    case (l)
      4'd1: case (c)
              0:  v = 16'h0001;
              1:  v = 16'h007D;
              2:  v = 16'h0027;
              3:  v = 16'h0003;
              4:  v = 16'hFFF0;
              11: v = 16'h0044;
              default: ;
            endcase
      4'd3: if (c == 0) v = 16'h001A;
      4'd4: if (c == 0) v = 16'hFFFA;
      4'd7: if (c % 2 == 1) v = ~v + 16'd1;
      4'd8: begin
              if (c % 2 == 1) v = ~v + 16'd1;
              if (c == 0)  v = 16'h000F;
              if (c == 35) v = 16'h0014;
            end
      4'd9: begin
              if (c == 0) v = 16'hFFF0;
              if (c == 9) v = 16'hFFF2;
            end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] b);
    return {{16{b[15]}}, b};
  endfunction

  // Packs a layer's biases right-aligned, channel 0 in the top used slice.
  function automatic logic [575:0] build_lut(input logic [3:0] a);
    logic [575:0] w;
    int n;
    w = '0;
    n = tb_count(a);
    for (int c = 0; c < n; c++) w[16*(n-1-c) +: 16] = chan_val(a, c);
    return w;
  endfunction

  assign lut_data = build_lut(lut_addr);

  // Starts layer l and consumes n beats; ready is random when rnd is set.
  task automatic run_stream(input logic [3:0] l, input int n, input bit rnd);
    int k;
    int cyc;
    bit stalled;
    logic [31:0] h_data;
    logic [5:0]  h_chan;
    logic        h_last;
    start = 1'b1;
    layer = l;
    @(posedge clk); #1;
    start = noise_start;
    layer = noise_start ? 4'd2 : 4'(l + 4'd1);
    checks++;
    if (busy !== 1'b1 || bias_valid !== 1'b0 || lut_addr !== l || done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_l%0d busy=%b valid=%b addr=%0d done=%b want 1 0 %0d 0",
               l, busy, bias_valid, lut_addr, done, l);
    end
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    while (k < n && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (noise_start && cyc >= 3) start = 1'b0;
      checks++;
      if (bias_valid !== 1'b1 || err !== 1'b0 || lut_addr !== l) begin
        errors++;
        $display("FAIL stream_l%0d_beat%0d valid=%b err=%b addr=%0d want 1 0 %0d",
                 l, k, bias_valid, err, lut_addr, l);
        break;
      end
      if (stalled) begin
        checks++;
        if ({bias_data, bias_chan, bias_last} !== {h_data, h_chan, h_last}) begin
          errors++;
          $display("FAIL stall_l%0d_beat%0d got %h/%0d/%b want %h/%0d/%b",
                   l, k, bias_data, bias_chan, bias_last, h_data, h_chan, h_last);
        end
      end
      bias_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bias_ready) begin
        checks++;
        if (bias_data !== sext16(chan_val(l, k))) begin
          errors++;
          $display("FAIL data_l%0d_beat%0d got %h want %h", l, k, bias_data, sext16(chan_val(l, k)));
        end
        checks++;
        if (bias_chan !== 6'(k) || bias_last !== (k == n - 1)) begin
          errors++;
          $display("FAIL chan_l%0d_beat%0d got chan %0d last %b want %0d %b",
                   l, k, bias_chan, bias_last, k, (k == n - 1));
        end
        k++;
        stalled = 1'b0;
      end else begin
        h_data = bias_data;
        h_chan = bias_chan;
        h_last = bias_last;
        stalled = 1'b1;
      end
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL beats_l%0d got %0d want %0d", l, k, n);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || bias_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_l%0d done=%b valid=%b busy=%b want 1 0 0", l, done, bias_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lut_addr, bias_valid, bias_data, bias_chan, bias_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs addr=%0d valid=%b data=%h chan=%0d last=%b busy=%b done=%b err=%b want all 0",
               lut_addr, bias_valid, bias_data, bias_chan, bias_last, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_layer1();
    run_stream(4'd1, 12, 1'b0);
  endtask

  // Layer 9 starts in the very cycle layer 1 reports done.
  task automatic test_back_to_back();
    run_stream(4'd9, 10, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_ready_stalls();
    run_stream(4'd8, 36, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3] = '{4'd0, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      layer = bad[i];
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || bias_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_l%0d err=%b busy=%b valid=%b want 1 0 0", bad[i], err, busy, bias_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || bias_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_after_l%0d err=%b busy=%b valid=%b want 0 0 0", bad[i], err, busy, bias_valid);
      end
    end
  endtask

  // A layer-2 start held during a layer-4 stream must be ignored.
  task automatic test_busy_ignore();
    noise_start = 1'b1;
    run_stream(4'd4, 24, 1'b0);
    noise_start = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bias_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_tail busy=%b valid=%b err=%b want 0 0 0", busy, bias_valid, err);
    end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    start = 1'b1;
    layer = 4'd7;
    bias_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bias_chan !== 6'd5 || bias_data !== sext16(chan_val(4'd7, 5)) || bias_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_beat5 chan=%0d data=%h valid=%b want 5 %h 1",
               bias_chan, bias_data, bias_valid, sext16(chan_val(4'd7, 5)));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lut_addr, bias_valid, bias_data, bias_chan, bias_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs addr=%0d valid=%b data=%h chan=%0d last=%b busy=%b done=%b err=%b want all 0",
               lut_addr, bias_valid, bias_data, bias_chan, bias_last, busy, done, err);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done saw done or busy after reset, want neither");
    end
    run_stream(4'd3, 12, 1'b0);
  endtask

  initial begin
    test_reset();
    test_layer1();
    test_back_to_back();
    test_ready_stalls();
    test_illegal();
    test_busy_ignore();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
